depth_test: RTL and testbench
=============================

// Module: depth_test
// PURPOSE
//  Per-fragment z-buffer stage downstream of the fragment shader. Takes one shaded fragment per cycle (x,y,z,rgb).
//  Reads the stored depth from an external z-buffer BRAM, keeps the fragment only if strictly closer, and writes z and rgb.
//  Owns frame clear: sweeps every pixel to far depth and background colour. No backpressure; input is fire-and-forget.
// PARAMETERS
//  H_RES        320     pixels per line; addr = y*H_RES + x
//  V_RES        240     lines per frame
//  READ_LATENCY 2       z-buffer BRAM read latency, cycles (>=1)
//  CLEAR_RGB    12'h000 colour written to framebuffer on clear
// PORTS
//  clk_in             in   1   clock
//  rst_n_in           in   1   reset, asynchronous, active-low
//  clear_in           in   1   1-cycle pulse: start frame clear
//  valid_in           in   1   fragment valid
//  x_in               in   9   fragment column
//  y_in               in   8   fragment row
//  z_in               in   16  depth, unsigned, smaller = closer
//  rgb_in             in   12  4:4:4 colour
//  zbuf_raddr_out     out  17  z-buffer read address
//  zbuf_rdata_in      in   16  read data, READ_LATENCY cycles after addr
//  zbuf_we_out        out  1   z-buffer write enable
//  zbuf_waddr_out     out  17  z-buffer write address
//  zbuf_wdata_out     out  16  z-buffer write data
//  fb_we_out          out  1   framebuffer write enable
//  fb_addr_out        out  17  framebuffer write address
//  fb_data_out        out  12  framebuffer write data
//  busy_out           out  1   draining/clearing; fragments dropped
//  dropped_count_out  out  16  saturating count of dropped fragments
// BEHAVIOUR
//  Reset: all outputs/valid bits 0, dropped_count 0; on release enter CLEAR with sweep addr 0.
//  States: RUN (accept), DRAIN (flush READ_LATENCY+2 cycles, no new fragments), CLEAR (sweep).
//  RUN --clear_in--> DRAIN --count done--> CLEAR --addr==H_RES*V_RES-1 written--> RUN. clear_in outside RUN ignored.
//  busy_out = (state != RUN), registered, valid from the same edge as the state change.
//  Stage 0 (edge after valid_in): register fields, addr = y*H_RES + x (17b). x>=H_RES or y>=V_RES: drop silently, no count.
//  zbuf_raddr_out driven from stage-0 addr register; rdata sampled READ_LATENCY cycles later.
//  Compare: pass iff z < stored_z (strict; equal fails). On pass, next edge: zbuf_we/fb_we=1 with addr, z, rgb.
//  Latency valid_in -> write strobes = READ_LATENCY+2 cycles (4 at default). One write per passing fragment.
//  Hazard: the stored_z used is the newest z written or pending for the same addr among the last READ_LATENCY+1 fragments.
//   That forwarded value is used instead of the BRAM data, so back-to-back same-pixel fragments resolve in order.
//  CLEAR: one pixel per cycle, zbuf_wdata=16'hFFFF, fb_data=CLEAR_RGB, both we=1; H_RES*V_RES cycles total.
//  valid_in while busy_out=1: fragment dropped; dropped_count++ (saturates at 16'hFFFF).
//  valid_in on the same cycle as clear_in in RUN: fragment accepted (finishes within DRAIN).
//  Async reset mid-sweep or mid-pipeline: all in-flight fragments discarded; clear restarts from 0.
//  Write strobes low whenever no write; addr/data don't-care then.
// TESTING
//  Reset release -> busy_out=1 for 76800 cycles of writes addr 0..76799 (z=FFFF, rgb=000), then busy_out=0.
//  Fragment (10,5,z=100,rgb=F00) after clear -> 4 cycles later fb_we=1, addr=1610, data=F00, zbuf z=100.
//  Same pixel, back-to-back cycles z=300, 200, 250 -> writes for 300 and 200 only; final stored z=200.
//  Fragment z=200 onto stored z=200 -> no write; x=320 or y=240 -> no write, dropped_count unchanged.
//  clear_in, then 3 fragments during busy -> dropped_count=3, none written; sweep completes normally.
//  Assert rst_n_in low mid-clear at addr 500 -> outputs 0 immediately; after release sweep restarts at addr 0.

Source files
------------

// File: rtl/depth_test.sv
// depth_test: z-buffer depth test stage with same-pixel forwarding and a frame clear sweep.
// Fragments pass only when strictly closer than the stored depth; passing fragments write z and colour.
module depth_test #(
  parameter int          H_RES        = 320,
  parameter int          V_RES        = 240,
  parameter int          READ_LATENCY = 2,
  parameter logic [11:0] CLEAR_RGB    = 12'h000
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        clear_in,
  input  logic        valid_in,
  input  logic [8:0]  x_in,
  input  logic [7:0]  y_in,
  input  logic [15:0] z_in,
  input  logic [11:0] rgb_in,
  output logic [16:0] zbuf_raddr_out,
  input  logic [15:0] zbuf_rdata_in,
  output logic        zbuf_we_out,
  output logic [16:0] zbuf_waddr_out,
  output logic [15:0] zbuf_wdata_out,
  output logic        fb_we_out,
  output logic [16:0] fb_addr_out,
  output logic [11:0] fb_data_out,
  output logic        busy_out,
  output logic [15:0] dropped_count_out
);
  localparam int          L          = READ_LATENCY;
  localparam logic [16:0] NPIX       = 17'(H_RES * V_RES);
  localparam logic [7:0]  DRAIN_LAST = 8'(L + 1);
  localparam logic [1:0]  S_RUN      = 2'd0;
  localparam logic [1:0]  S_DRAIN    = 2'd1;
  localparam logic [1:0]  S_CLEAR    = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [16:0] sweep_q, sweep_d;
  logic        busy_q;
  logic [15:0] drop_q, drop_d;
  logic        pv_q [0:L];
  logic [16:0] pa_q [0:L];
  logic [15:0] pz_q [0:L];
  logic [11:0] pc_q [0:L];
  logic        hv_q [0:L-1];
  logic [16:0] ha_q [0:L-1];
  logic [15:0] hz_q [0:L-1];
  logic        we_q, we_d;
  logic [16:0] wa_q, wa_d;
  logic [15:0] wz_q, wz_d;
  logic [11:0] wc_q, wc_d;
  logic        accept, clr_wr, pass;
  logic [15:0] fwd_z;
  logic [16:0] addr0;

  assign addr0  = 17'(y_in) * 17'(H_RES) + 17'(x_in);
  assign accept = valid_in && state_q == S_RUN && x_in < 9'(H_RES) && y_in < 8'(V_RES);
  // sweep_q == NPIX marks the cycle in which the last clear write is on the outputs
  assign clr_wr = state_q == S_CLEAR && sweep_q != NPIX;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 8'd1;
    sweep_d = sweep_q;
    if (state_q == S_RUN && clear_in) begin
      state_d = S_DRAIN;
      cnt_d   = 8'd0;
    end
    if (state_q == S_DRAIN && cnt_q == DRAIN_LAST) begin
      state_d = S_CLEAR;
      sweep_d = '0;
    end
    if (state_q == S_CLEAR) begin
      state_d = clr_wr ? S_CLEAR : S_RUN;
      sweep_d = sweep_q + (clr_wr ? 17'd1 : 17'd0);
    end
  end

  assign drop_d = (valid_in && state_q != S_RUN && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;

  // Writes not yet visible to the BRAM read override it, newest first
  always_comb begin
    fwd_z = zbuf_rdata_in;
    for (int k = L - 1; k >= 0; k--)
      if (hv_q[k] && ha_q[k] == pa_q[L]) fwd_z = hz_q[k];
    if (we_q && wa_q == pa_q[L]) fwd_z = wz_q;
  end

  assign pass = pv_q[L] && pz_q[L] < fwd_z;
  assign we_d = clr_wr || pass;
  assign wa_d = clr_wr ? sweep_q : pa_q[L];
  assign wz_d = clr_wr ? 16'hFFFF : pz_q[L];
  assign wc_d = clr_wr ? CLEAR_RGB : pc_q[L];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
      sweep_q <= '0;
      busy_q  <= 1'b0;
      drop_q  <= '0;
      we_q    <= 1'b0;
      wa_q    <= '0;
      wz_q    <= '0;
      wc_q    <= '0;
      for (int i = 0; i <= L; i++) begin
        pv_q[i] <= 1'b0;
        pa_q[i] <= '0;
        pz_q[i] <= '0;
        pc_q[i] <= '0;
      end
      for (int i = 0; i < L; i++) begin
        hv_q[i] <= 1'b0;
        ha_q[i] <= '0;
        hz_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sweep_q <= sweep_d;
      busy_q  <= state_d != S_RUN;
      drop_q  <= drop_d;
      we_q    <= we_d;
      wa_q    <= wa_d;
      wz_q    <= wz_d;
      wc_q    <= wc_d;
      pv_q[0] <= accept;
      if (accept) begin
        pa_q[0] <= addr0;
        pz_q[0] <= z_in;
        pc_q[0] <= rgb_in;
      end
      for (int i = 1; i <= L; i++) begin
        pv_q[i] <= pv_q[i-1];
        pa_q[i] <= pa_q[i-1];
        pz_q[i] <= pz_q[i-1];
        pc_q[i] <= pc_q[i-1];
      end
      hv_q[0] <= we_q;
      ha_q[0] <= wa_q;
      hz_q[0] <= wz_q;
      for (int i = 1; i < L; i++) begin
        hv_q[i] <= hv_q[i-1];
        ha_q[i] <= ha_q[i-1];
        hz_q[i] <= hz_q[i-1];
      end
    end
  end

  assign zbuf_raddr_out    = pa_q[0];
  assign zbuf_we_out       = we_q;
  assign zbuf_waddr_out    = wa_q;
  assign zbuf_wdata_out    = wz_q;
  assign fb_we_out         = we_q;
  assign fb_addr_out       = wa_q;
  assign fb_data_out       = wc_q;
  assign busy_out          = busy_q;
  assign dropped_count_out = drop_q;
endmodule

// File: tb/tb_depth_test.sv
// tb_depth_test: drives depth_test against a latency-modelled z-buffer BRAM and a per-pixel depth reference.
module tb_depth_test;
  localparam int          H    = 40;
  localparam int          V    = 30;
  localparam int          L    = 2;
  localparam int          N    = H * V;
  localparam logic [11:0] CRGB = 12'h5A3;

  logic        clk = 1'b0, rst_n = 1'b0, clear = 1'b0, valid = 1'b0;
  logic [8:0]  x = '0;
  logic [7:0]  y = '0;
  logic [15:0] z = '0;
  logic [11:0] rgb = '0;
  logic [16:0] raddr, zwaddr, faddr;
  logic [15:0] rdata, zwdata, dcnt;
  logic        zwe, fwe, busy;
  logic [11:0] fdata;
  int          n_chk = 0, n_fail = 0, cyc = 0;

  typedef struct {int t; logic zw; logic fw; logic b; logic [16:0] za; logic [16:0] fa; logic [15:0] z; logic [11:0] c;} wr_t;
  wr_t         obs_q[$];
  wr_t         exp_q[$];
  logic [15:0] zmem [0:N-1];
  logic [15:0] rpipe [0:L-1];
  int          ref_z [0:N-1];

  depth_test #(.H_RES(H), .V_RES(V), .READ_LATENCY(L), .CLEAR_RGB(CRGB)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .clear_in(clear), .valid_in(valid),
    .x_in(x), .y_in(y), .z_in(z), .rgb_in(rgb),
    .zbuf_raddr_out(raddr), .zbuf_rdata_in(rdata),
    .zbuf_we_out(zwe), .zbuf_waddr_out(zwaddr), .zbuf_wdata_out(zwdata),
    .fb_we_out(fwe), .fb_addr_out(faddr), .fb_data_out(fdata),
    .busy_out(busy), .dropped_count_out(dcnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (zwe && int'(zwaddr) < N) zmem[int'(zwaddr)] <= zwdata;
    rpipe[0] <= (int'(raddr) < N) ? zmem[int'(raddr)] : 16'h0000;
    for (int k = 1; k < L; k++) rpipe[k] <= rpipe[k-1];
  end
  assign rdata = rpipe[L-1];

  always @(negedge clk)
    if (zwe || fwe) obs_q.push_back('{t: cyc, zw: zwe, fw: fwe, b: busy, za: zwaddr, fa: faddr, z: zwdata, c: fdata});

  task automatic frag(input logic v, input int xx, input int yy, input int zz, input int cc, input bit acc);
    @(negedge clk);
    valid = v; x = 9'(xx); y = 8'(yy); z = 16'(zz); rgb = 12'(cc);
    if (v && acc && xx < H && yy < V && zz < ref_z[yy*H+xx]) begin
      exp_q.push_back('{t: cyc + L + 2, zw: 1'b1, fw: 1'b1, b: 1'b0, za: 17'(yy*H+xx), fa: 17'(yy*H+xx), z: 16'(zz), c: 12'(cc)});
      ref_z[yy*H+xx] = zz;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid = 1'b0; clear = 1'b0;
    end
  endtask

  task automatic test_reset;
    int base, nb, bad, first;
    repeat (3) @(negedge clk);
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_chk++; if ({zwe, fwe} !== 2'b00) begin n_fail++; $display("FAIL reset_we: got %b%b want 00", zwe, fwe); end
    n_chk++; if ({dcnt, raddr} !== 33'd0) begin n_fail++; $display("FAIL reset_regs: dropped %0d raddr %0d want 0 0", dcnt, raddr); end
    base = obs_q.size();
    rst_n = 1'b1;
    nb = 0;
    for (int i = 0; i < 5 && !busy; i++) @(negedge clk);
    while (busy === 1'b1 && nb < N + 50) begin nb++; @(negedge clk); end
    n_chk++; if (nb !== N) begin n_fail++; $display("FAIL reset_busy_len: got %0d cycles want %0d", nb, N); end
    n_chk++; if (obs_q.size() - base !== N) begin n_fail++; $display("FAIL reset_sweep_count: got %0d writes want %0d", obs_q.size() - base, N); end
    bad = 0; first = -1;
    for (int i = 0; i < N && base + i < obs_q.size(); i++) begin
      wr_t o = obs_q[base+i];
      if ({o.zw, o.fw, o.b, o.za, o.fa, o.z, o.c} !== {3'b111, 17'(i), 17'(i), 16'hFFFF, CRGB}) begin bad++; if (first < 0) first = i; end
    end
    n_chk++; if (bad !== 0) begin n_fail++; $display("FAIL reset_sweep: %0d bad writes, first at index %0d addr %0d z %h rgb %h want addr %0d z FFFF rgb %h", bad, first, obs_q[base+first].za, obs_q[base+first].z, obs_q[base+first].c, first, CRGB); end
    for (int a = 0; a < N; a++) ref_z[a] = 16'hFFFF;
  endtask

  task automatic test_fragment;
    int base = obs_q.size();
    exp_q.delete();
    frag(1'b1, 10, 5, 100, 12'hF00, 1'b1);
    idle(L + 4);
    n_chk++; if (obs_q.size() - base !== 1) begin n_fail++; $display("FAIL frag_count: got %0d writes want 1", obs_q.size() - base); end
    else begin
      wr_t o = obs_q[base];
      n_chk++; if (o.t !== exp_q[0].t) begin n_fail++; $display("FAIL frag_latency: write at cycle %0d want %0d", o.t, exp_q[0].t); end
      n_chk++; if ({o.zw, o.fw, o.za, o.fa} !== {2'b11, 17'd210, 17'd210}) begin n_fail++; $display("FAIL frag_addr: zaddr %0d faddr %0d want 210", o.za, o.fa); end
      n_chk++; if ({o.z, o.c} !== {16'd100, 12'hF00}) begin n_fail++; $display("FAIL frag_data: z %0d rgb %h want 100 F00", o.z, o.c); end
    end
  endtask

  task automatic test_back_to_back;
    int base = obs_q.size();
    exp_q.delete();
    frag(1'b1, 7, 3, 300, 12'h111, 1'b1);
    frag(1'b1, 7, 3, 200, 12'h222, 1'b1);
    frag(1'b1, 7, 3, 250, 12'h333, 1'b1);
    idle(L + 4);
    n_chk++; if (obs_q.size() - base !== exp_q.size()) begin n_fail++; $display("FAIL b2b_count: got %0d writes want %0d", obs_q.size() - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
      wr_t o = obs_q[base+i];
      n_chk++;
      if ({o.t, o.za, o.fa, o.z, o.c} !== {exp_q[i].t, exp_q[i].za, exp_q[i].za, exp_q[i].z, exp_q[i].c}) begin
        n_fail++; $display("FAIL b2b_write[%0d]: t %0d addr %0d z %0d rgb %h want t %0d addr %0d z %0d rgb %h", i, o.t, o.za, o.z, o.c, exp_q[i].t, exp_q[i].za, exp_q[i].z, exp_q[i].c);
      end
    end
    n_chk++; if (zmem[3*H+7] !== 16'd200) begin n_fail++; $display("FAIL b2b_stored: got %0d want 200", zmem[3*H+7]); end
  endtask

  task automatic test_reject;
    int base = obs_q.size();
    logic [15:0] d0 = dcnt;
    exp_q.delete();
    frag(1'b1, 7, 3, 200, 12'hABC, 1'b1);
    frag(1'b1, H, 0, 1, 12'hABC, 1'b1);
    frag(1'b1, 0, V, 1, 12'hABC, 1'b1);
    frag(1'b1, H - 1, V - 1, 5, 12'h0F0, 1'b1);
    idle(L + 4);
    n_chk++; if (obs_q.size() - base !== 1) begin n_fail++; $display("FAIL reject_count: got %0d writes want 1", obs_q.size() - base); end
    else begin
      n_chk++; if ({obs_q[base].za, obs_q[base].z, obs_q[base].c} !== {17'(N - 1), 16'd5, 12'h0F0}) begin n_fail++; $display("FAIL corner_write: addr %0d z %0d rgb %h want %0d 5 0F0", obs_q[base].za, obs_q[base].z, obs_q[base].c, N - 1); end
    end
    n_chk++; if (dcnt !== d0) begin n_fail++; $display("FAIL reject_dropped: got %0d want %0d", dcnt, d0); end
  endtask

  task automatic test_random;
    int base = obs_q.size();
    exp_q.delete();
    for (int n = 0; n < 300; n++) begin
      int xx = $urandom_range(0, 5);
      int yy = $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) xx = H + $urandom_range(0, 20);
      if ($urandom_range(0, 9) == 0) yy = V + $urandom_range(0, 10);
      frag($urandom_range(0, 9) < 7, xx, yy, $urandom_range(0, 3000), $urandom_range(0, 4095), 1'b1);
    end
    idle(L + 4);
    n_chk++; if (obs_q.size() - base !== exp_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d writes want %0d", obs_q.size() - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
      wr_t o = obs_q[base+i];
      n_chk++;
      if ({o.zw, o.fw, o.t, o.za, o.fa, o.z, o.c} !== {2'b11, exp_q[i].t, exp_q[i].za, exp_q[i].za, exp_q[i].z, exp_q[i].c}) begin
        n_fail++; $display("FAIL rand_write[%0d]: t %0d addr %0d z %0d rgb %h want t %0d addr %0d z %0d rgb %h", i, o.t, o.za, o.z, o.c, exp_q[i].t, exp_q[i].za, exp_q[i].z, exp_q[i].c);
      end
    end
  endtask

  task automatic test_clear_drop;
    int base = obs_q.size();
    int nb = 0, bad = 0, first = -1;
    logic [15:0] d0 = dcnt;
    exp_q.delete();
    frag(1'b1, 20, 10, 50, 12'hABC, 1'b1);
    clear = 1'b1;
    frag(1'b1, 21, 10, 10, 12'h111, 1'b0);
    clear = 1'b0;
    frag(1'b1, 22, 10, 10, 12'h222, 1'b0);
    frag(1'b1, 23, 10, 10, 12'h333, 1'b0);
    idle(1);
    while (busy === 1'b1 && nb < N + 50) begin nb++; @(negedge clk); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clear_timeout: busy %b after %0d cycles want 0", busy, nb); end
    n_chk++; if (dcnt !== d0 + 16'd3) begin n_fail++; $display("FAIL clear_dropped: got %0d want %0d", dcnt, d0 + 16'd3); end
    n_chk++; if (obs_q.size() - base !== N + 1) begin n_fail++; $display("FAIL clear_count: got %0d writes want %0d", obs_q.size() - base, N + 1); end
    else begin
      wr_t o = obs_q[base];
      n_chk++; if ({o.t, o.za, o.z, o.c} !== {exp_q[0].t, exp_q[0].za, exp_q[0].z, exp_q[0].c}) begin n_fail++; $display("FAIL clear_accepted: t %0d addr %0d z %0d rgb %h want t %0d addr %0d z 50 rgb ABC", o.t, o.za, o.z, o.c, exp_q[0].t, exp_q[0].za); end
      for (int i = 0; i < N; i++) begin
        wr_t s = obs_q[base+1+i];
        if ({s.zw, s.fw, s.b, s.za, s.fa, s.z, s.c} !== {3'b111, 17'(i), 17'(i), 16'hFFFF, CRGB}) begin bad++; if (first < 0) first = i; end
      end
      n_chk++; if (bad !== 0) begin n_fail++; $display("FAIL clear_sweep: %0d bad writes, first at index %0d addr %0d z %h want addr %0d z FFFF", bad, first, obs_q[base+1+first].za, obs_q[base+1+first].z, first); end
    end
    for (int a = 0; a < N; a++) ref_z[a] = 16'hFFFF;
  endtask

  task automatic test_reset_mid_clear;
    int base, nb = 0, bad = 0, first = -1;
    bit found = 0;
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    for (int i = 0; i < N && !found; i++) begin
      @(negedge clk);
      if (zwe && zwaddr == 17'd500) found = 1;
    end
    n_chk++; if (!found) begin n_fail++; $display("FAIL mid_reach500: write to addr 500 not seen, got addr %0d", zwaddr); end
    rst_n = 1'b0;
    #1;
    n_chk++; if ({zwe, fwe, busy} !== 3'b000) begin n_fail++; $display("FAIL mid_reset_ctl: we %b%b busy %b want 000", zwe, fwe, busy); end
    n_chk++; if ({dcnt, raddr, zwaddr, zwdata, fdata} !== 78'd0) begin n_fail++; $display("FAIL mid_reset_data: dropped %0d raddr %0d waddr %0d wdata %h fb %h want all 0", dcnt, raddr, zwaddr, zwdata, fdata); end
    repeat (2) @(negedge clk);
    base = obs_q.size();
    rst_n = 1'b1;
    for (int i = 0; i < 5 && !busy; i++) @(negedge clk);
    while (busy === 1'b1 && nb < N + 50) begin nb++; @(negedge clk); end
    n_chk++; if (nb !== N) begin n_fail++; $display("FAIL mid_busy_len: got %0d cycles want %0d", nb, N); end
    n_chk++; if (obs_q.size() - base !== N) begin n_fail++; $display("FAIL mid_sweep_count: got %0d writes want %0d", obs_q.size() - base, N); end
    for (int i = 0; i < N && base + i < obs_q.size(); i++) begin
      wr_t o = obs_q[base+i];
      if ({o.zw, o.fw, o.za, o.z, o.c} !== {2'b11, 17'(i), 16'hFFFF, CRGB}) begin bad++; if (first < 0) first = i; end
    end
    n_chk++; if (bad !== 0) begin n_fail++; $display("FAIL mid_sweep: %0d bad writes, first at index %0d addr %0d want %0d", bad, first, obs_q[base+first].za, first); end
  endtask

  initial begin
    test_reset;
    test_fragment;
    test_back_to_back;
    test_reject;
    test_random;
    test_clear_drop;
    test_reset_mid_clear;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
endmodule
